// File: rtl/seg7_bcd_scanner.sv
// Binary-to-BCD converter (serial double-dabble) feeding a multiplexed 7-segment scanner.
// The display reads only the held bcd register and is refreshed by a free-running digit scan.
module seg7_bcd_scanner #(
    parameter int WIDTH    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [31:0]      BIN_MAX  = 32'(10 ** DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] dig);
        logic [6:0] pat;
        case (dig)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] bin_sh_r;
    logic [BCD_W-1:0] bcd_sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_cap_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;
    logic [BCD_W-1:0] bcd_r;
    logic [DIV_W-1:0] div_r;
    logic [IDX_W-1:0] idx_r;

    logic [BCD_W-1:0]  bcd_adj_s;
    logic [3:0]        digit_s;
    logic              blank_s;
    logic [DIGITS-1:0] digit_en_s;
    logic [6:0]        seg_s;

    // Add-3 correction on every nibble of the shift register ahead of the shift.
    always_comb begin
        bcd_adj_s = {BCD_W{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            bcd_adj_s[4*k +: 4] = dd_adjust(bcd_sh_r[4*k +: 4]);
        end
    end

    // Conversion FSM; overflow is decided from the captured value, so only DIGITS nibbles are shifted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bin_sh_r  <= {WIDTH{1'b0}};
            bcd_sh_r  <= {BCD_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_cap_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
            bcd_r     <= {BCD_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bin_sh_r  <= bin;
                        bcd_sh_r  <= {BCD_W{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        ovf_cap_r <= (32'(bin) > BIN_MAX);
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_sh_r <= {bcd_adj_s[BCD_W-2:0], bin_sh_r[WIDTH-1]};
                    bin_sh_r <= {bin_sh_r[WIDTH-2:0], 1'b0};
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_r   <= ovf_cap_r ? {DIGITS{4'h9}} : bcd_sh_r;
                    ovf_r   <= ovf_cap_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running scan: hold each position SCAN_DIV cycles, then step the digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r <= {DIV_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (div_r == DIV_LAST) begin
            div_r <= {DIV_W{1'b0}};
            idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Digit select and leading-zero blanking, scanning from the top digit down.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        digit_s    = 4'h0;
        blank_s    = 1'b0;
        digit_en_s = {DIGITS{1'b0}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && (bcd_r[4*k +: 4] == 4'h0);
            digit_en_s[k] = (idx_r == IDX_W'(k));
            digit_s       = digit_en_s[k] ? bcd_r[4*k +: 4] : digit_s;
            blank_s       = digit_en_s[k] ? (blank_lz && (k != 0) && zero_run) : blank_s;
        end
        seg_s = blank_s ? 7'h00 : seg_encode(digit_s);
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign ovf      = ovf_r;
    assign bcd      = bcd_r;
    assign digit_en = digit_en_s;
    assign seg      = seg_s;

endmodule

// File: tb/tb_seg7_bcd_scanner.sv
// Self-checking bench for seg7_bcd_scanner at default parameters: directed steps plus random
// conversions checked against an arithmetic reference model of the conversion and display.
module tb_seg7_bcd_scanner;

    localparam int W = 14;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  bin;
    logic          blank_lz;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [15:0]   bcd;
    logic [3:0]    digit_en;
    logic [6:0]    seg;

    int n_total = 0;
    int n_pass  = 0;
    int ecount  = 0;
    logic [15:0] mbcd = 16'h0;
    int lat;

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_bcd_scanner dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .bcd      (bcd),
        .digit_en (digit_en),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int p;
        r = 16'h0;
        p = v;
        if (v > 9999) return 16'h9999;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] ref_seg(input logic [15:0] b, input int pos, input logic blz);
        logic [15:0] upper;
        upper = b >> (4 * pos);
        if (blz && pos != 0 && upper == 16'h0) return 7'h00;
        return segtab[int'(upper[3:0])];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            ecount++;
        end else begin
            ecount = 0;
            mbcd   = 16'h0;
        end
        #1;
    endtask

    task automatic chk_disp(input string tag);
        int pos;
        pos = (ecount / 4) % 4;
        chk({tag, "_en"}, 32'(digit_en), 32'(1 << pos));
        chk({tag, "_seg"}, 32'(seg), 32'(ref_seg(mbcd, pos, blank_lz)));
    endtask

    // One conversion; with poke set, start is retried mid-shift (bin=5) and in the DONE cycle.
    task automatic conv(input int v, input bit poke, output int latency);
        int ndone;
        ndone   = 0;
        latency = -1;
        bin     = W'(v);
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (start) begin
                start = 1'b0;
                bin   = W'(v);
            end
            if (i == 15) mbcd = ref_bcd(v);
            if (done === 1'b1) begin
                ndone++;
                if (latency < 0) latency = i;
            end
            chk("busy", 32'(busy), (i < 15) ? 32'd1 : 32'd0);
            chk_disp("conv_disp");
            if (poke && (i == 5 || i == 14)) begin
                start = 1'b1;
                bin   = W'(5);
            end
        end
        chk("latency", 32'(latency), 32'd15);
        chk("done_count", 32'(ndone), 32'd1);
        chk("bcd", 32'(bcd), 32'(ref_bcd(v)));
        chk("ovf", 32'(ovf), (v > 9999) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        bin      = W'(0);
        blank_lz = 1'b0;

        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h0000);
        chk("rst_en", 32'(digit_en), 32'b0001);
        chk("rst_seg", 32'(seg), 32'h3F);
        rst_n = 1'b1;

        conv(1234, 1'b0, lat);
        conv(12000, 1'b0, lat);
        conv(9999, 1'b0, lat);
        conv(1234, 1'b1, lat);

        conv(407, 1'b0, lat);
        blank_lz = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk_disp("scan_blank");
        end
        blank_lz = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_disp("scan_noblank");
        end

        bin   = W'(1234);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk_disp("abort_disp");
        end
        chk("abort_bcd", 32'(bcd), 32'h0000);
        chk("abort_ovf", 32'(ovf), 32'd0);
        conv(42, 1'b0, lat);
        chk("bcd_42", 32'(bcd), 32'h0042);

        for (int r = 0; r < 8; r++) begin
            blank_lz = 1'($urandom_range(0, 1));
            conv(int'($urandom_range(0, 16383)), 1'b0, lat);
            for (int i = 0; i < 8; i++) begin
                tick();
                chk_disp("rand_disp");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_bcd_scanner.md
SEG7_BCD_SCANNER -- requirements
Module: seg7_bcd_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 14, binary input width (4..20).
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD digits/display positions (1..6).
REQ-003 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit is enabled (>=1).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request conversion of bin; sampled only in IDLE.
REQ-007 bin  input  WIDTH  unsigned binary value.
REQ-008 blank_lz  input  1  1 = blank leading zero digits.
REQ-009 busy  output  1  high while conversion in progress.
REQ-010 done  output  1  one-cycle pulse when bcd/ovf update.
REQ-011 ovf  output  1  last converted value exceeded 10^DIGITS-1.
REQ-012 bcd  output  4*DIGITS  converted value, digit k at bits [4k+3:4k], digit 0 least significant.
REQ-013 digit_en  output  DIGITS  one-hot active-high enable of displayed position.
REQ-014 seg  output  7  active-high segments, bit0=a ... bit6=g, for the enabled position.

Function
REQ-015 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-016 IDLE with start=1 SHALL capture bin, clear the shift register, and enter SHIFT; busy=1 from the next cycle.
REQ-017 SHIFT SHALL perform one double-dabble step per cycle (add 3 to every BCD nibble >=5, then shift in next bin bit MSB first) for exactly WIDTH cycles, then enter DONE.
REQ-018 DONE SHALL, for one cycle, load bcd and ovf, assert done, deassert busy, and return to IDLE.
REQ-019 done SHALL occur WIDTH+1 cycles after the cycle start was sampled.
REQ-020 If captured bin > 10^DIGITS-1, bcd SHALL saturate to all nibbles 4'h9 and ovf=1; otherwise ovf=0.
REQ-021 start while busy or in DONE SHALL be ignored; no queueing.
REQ-022 bcd and ovf SHALL hold between conversions; the display SHALL use only the held bcd, never intermediate shift state.
REQ-023 A free-running scan counter SHALL advance the digit index every SCAN_DIV cycles, 0,1,..,DIGITS-1, wrapping to 0; it runs independently of the FSM.
REQ-024 digit_en SHALL be the one-hot decode of the digit index.
REQ-025 seg SHALL encode the indexed digit: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex).
REQ-026 With blank_lz=1, a zero digit above the most significant nonzero digit SHALL give seg=00; digit 0 is never blanked.
REQ-027 A bcd update mid-scan SHALL take effect on seg the same cycle without disturbing the scan index.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, ovf=0, bcd=0, scan counter and index=0.
REQ-029 After reset digit_en SHALL equal 1 (position 0) and seg SHALL equal 7'h3F.
REQ-030 Reset during SHIFT SHALL abort the conversion with no done pulse and bcd=0.

Verification (defaults WIDTH=14, DIGITS=4, SCAN_DIV=4)
REQ-031 Hold rst_n=0 two cycles -> busy=0, done=0, ovf=0, bcd=16'h0000, digit_en=4'b0001, seg=7'h3F.
REQ-032 bin=1234, start pulse -> busy next cycle, done 15 cycles after start, bcd=16'h1234, ovf=0.
REQ-033 bin=12000 -> bcd=16'h9999, ovf=1; then bin=9999 -> bcd=16'h9999, ovf=0.
REQ-034 start with bin=5 during conversion of 1234 -> result 16'h1234, exactly one done pulse.
REQ-035 bcd=16'h0407, blank_lz=1 -> per position, 4 cycles each, digit_en 0001/0010/0100/1000 with seg 07/3F/66/00, then wrap; blank_lz=0 -> position 3 seg=3F.
REQ-036 Assert rst_n=0 at SHIFT cycle 7 -> no done, bcd=0; next start with bin=42 -> bcd=16'h0042.
